// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer and the parametrised FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] Din;
  logic              WR_EN;
  logic              RD_EN;
  logic              ClrErr;
  logic [DATA_W-1:0] DOut;
  logic              DValid;
  logic              Empty;
  logic              Full;
  logic              AlmostFull;
  logic              AlmostEmpty;
  logic [CW-1:0]     Count;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Din, WR_EN, RD_EN, ClrErr,
    input  DOut, DValid, Empty, Full, AlmostFull, AlmostEmpty, Count, Overflow, Underflow
  );

  modport slave (
    input  Din, WR_EN, RD_EN, ClrErr,
    output DOut, DValid, Empty, Full, AlmostFull, AlmostEmpty, Count, Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: parametrised width/depth, standard or first-word-fall-through
// read, registered occupancy flags and sticky overflow/underflow errors.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 128,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic              CLK,
  input  logic              RST,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count, cnt_nxt;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              ovf_q, unf_q;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still takes a read
  // and an empty FIFO still takes a write in the same cycle.
  assign wr_acc = bus.WR_EN & ~full_q;
  assign rd_acc = bus.RD_EN & ~empty_q;

  // Next occupancy; simultaneous accepted read and write cancel out.
  always_comb begin
    cnt_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wptr] <= bus.Din;
  end

  // Pointers, occupancy and flags; flags come from cnt_nxt so they track the edge with no lag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      count    <= cnt_nxt;
      empty_q  <= (cnt_nxt == '0);
      full_q   <= (cnt_nxt == CW'(DEPTH));
      afull_q  <= (cnt_nxt >= CW'(AFULL_TH));
      aempty_q <= (cnt_nxt <= CW'(AEMPTY_TH));
    end
  end

  // Sticky errors: a new refused request beats a same-cycle clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.WR_EN & full_q)  | (ovf_q & ~bus.ClrErr);
      unf_q <= (bus.RD_EN & empty_q) | (unf_q & ~bus.ClrErr);
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              dvalid_q;
      // Registered read: data lands one cycle after the accepted read, strobed by DValid.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rptr];
        end
      end
      assign bus.DOut   = dout_q;
      assign bus.DValid = dvalid_q;
    end else begin : g_fwft
      // Head word is presented directly; RD_EN only advances the pointer.
      assign bus.DOut   = mem[rptr];
      assign bus.DValid = ~empty_q;
    end
  endgenerate

  assign bus.Empty       = empty_q;
  assign bus.Full        = full_q;
  assign bus.AlmostFull  = afull_q;
  assign bus.AlmostEmpty = aempty_q;
  assign bus.Count       = count;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard-read instance driven by a vector table and
// a queue model/scoreboard, plus a FWFT instance exercised by hand-written sequences.
module tb_sync_fifo_param;
  localparam int DW = 8, DEPTH = 16, AFT = 12, AET = 4;

  logic CLK = 1'b0;
  logic RST0 = 1'b1, RST1 = 1'b1;
  always #5 CLK = ~CLK;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) b0 ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) b1 ();

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(0))
    u0 (.CLK(CLK), .RST(RST0), .bus(b0));
  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1))
    u1 (.CLK(CLK), .RST(RST1), .bus(b1));

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state for the standard-read instance.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         movf, munf;
  logic [7:0] last_dout;

  task automatic step0(input bit wr, input bit rd, input bit clr, input logic [7:0] din);
    bit wa, ra;
    int mcnt;
    logic [7:0] e;
    b0.WR_EN = wr; b0.RD_EN = rd; b0.ClrErr = clr; b0.Din = din;
    wa = wr && (mq.size() < DEPTH);
    ra = rd && (mq.size() > 0);
    if (ra) sb.push_back(mq.pop_front());
    if (wa) mq.push_back(din);
    movf = (wr && !wa) || (movf && !clr);
    munf = (rd && !ra) || (munf && !clr);
    @(posedge CLK); #1;
    b0.WR_EN = 1'b0; b0.RD_EN = 1'b0; b0.ClrErr = 1'b0;
    mcnt = mq.size();
    chk("count", b0.Count, mcnt);
    chk("empty", b0.Empty, mcnt == 0);
    chk("full", b0.Full, mcnt == DEPTH);
    chk("afull", b0.AlmostFull, mcnt >= AFT);
    chk("aempty", b0.AlmostEmpty, mcnt <= AET);
    chk("ovf", b0.Overflow, movf);
    chk("unf", b0.Underflow, munf);
    chk("dvalid", b0.DValid, ra);
    if (b0.DValid === 1'b1) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL sb_underrun: DValid with no expected word at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("dout", b0.DOut, e);
        last_dout = e;
      end
    end else begin
      chk("dout_hold", b0.DOut, last_dout);
    end
  endtask

  typedef struct {
    bit wr, rd, clr;
    logic [7:0] din;
    int cnt;
    bit dv;
    logic [7:0] dout;
    bit unf;
  } vec_t;
  vec_t tv[11];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 1'b0, 8'h00, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b1, 8'h11, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'h22, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h33, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h33, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h33, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h33, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 8'h33, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h33, 1'b0};

    b0.WR_EN = 1'b0; b0.RD_EN = 1'b0; b0.ClrErr = 1'b0; b0.Din = '0;
    b1.WR_EN = 1'b0; b1.RD_EN = 1'b0; b1.ClrErr = 1'b0; b1.Din = '0;
    movf = 1'b0; munf = 1'b0; last_dout = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RST0 = 1'b0; RST1 = 1'b0;
    @(posedge CLK); #1;

    // Reset state.
    chk("rst_count", b0.Count, 0);
    chk("rst_empty", b0.Empty, 1);
    chk("rst_aempty", b0.AlmostEmpty, 1);
    chk("rst_full", b0.Full, 0);
    chk("rst_afull", b0.AlmostFull, 0);
    chk("rst_dvalid", b0.DValid, 0);
    chk("rst_dout", b0.DOut, 0);
    chk("rst_ovf", b0.Overflow, 0);
    chk("rst_unf", b0.Underflow, 0);

    // Basic write/read, underflow and error clear via the vector table.
    for (int i = 0; i < 11; i++) begin
      step0(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din);
      chk("tv_cnt", b0.Count, tv[i].cnt);
      chk("tv_dv", b0.DValid, tv[i].dv);
      chk("tv_dout", b0.DOut, tv[i].dout);
      chk("tv_unf", b0.Underflow, tv[i].unf);
    end

    // Fill to full (pointers start mid-array, so the drain wraps).
    for (int i = 0; i < DEPTH; i++) begin
      step0(1'b1, 1'b0, 1'b0, 8'(i));
      if (i + 1 == AFT) chk("afull_at_th", b0.AlmostFull, 1);
      if (i + 1 == AFT - 1) chk("afull_below_th", b0.AlmostFull, 0);
    end
    chk("full_hand", b0.Full, 1);
    chk("cnt_full_hand", b0.Count, DEPTH);
    step0(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_hand", b0.Overflow, 1);
    // Full + both: read taken, write refused.
    step0(1'b1, 1'b1, 1'b0, 8'h77);
    chk("cnt_full_both", b0.Count, DEPTH - 1);
    for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) step0(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drained_empty", b0.Empty, 1);
    step0(1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_cleared", b0.Overflow, 0);

    // Concurrent read/write at steady occupancy 5.
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) begin
      step0(1'b1, 1'b1, 1'b0, 8'(8'h50 + i));
      chk("cnt_steady5", b0.Count, 5);
    end
    for (int i = 0; i < 5; i++) step0(1'b0, 1'b1, 1'b0, 8'h00);
    chk("sb_drained", sb.size(), 0);

    // FWFT instance.
    chk("f_rst_empty", b1.Empty, 1);
    chk("f_rst_dv", b1.DValid, 0);
    b1.WR_EN = 1'b1; b1.Din = 8'hA5;
    @(posedge CLK); #1;
    b1.Din = 8'hB6;
    chk("f_dout_a5", b1.DOut, 8'hA5);
    chk("f_dv_a5", b1.DValid, 1);
    chk("f_cnt1", b1.Count, 1);
    @(posedge CLK); #1;
    b1.Din = 8'hC7;
    @(posedge CLK); #1;
    b1.WR_EN = 1'b0;
    chk("f_cnt3", b1.Count, 3);
    chk("f_head_a5", b1.DOut, 8'hA5);
    b1.RD_EN = 1'b1;
    @(posedge CLK); #1;
    b1.RD_EN = 1'b0;
    chk("f_pop_b6", b1.DOut, 8'hB6);
    chk("f_cnt2", b1.Count, 2);
    // Mid-burst asynchronous reset.
    b1.WR_EN = 1'b1; b1.Din = 8'hD8;
    @(posedge CLK); #1;
    chk("f_cnt_burst", b1.Count, 3);
    #2 RST1 = 1'b1;
    #1;
    chk("f_arst_cnt", b1.Count, 0);
    chk("f_arst_empty", b1.Empty, 1);
    chk("f_arst_dv", b1.DValid, 0);
    chk("f_arst_aempty", b1.AlmostEmpty, 1);
    b1.WR_EN = 1'b0;
    @(posedge CLK); #1;
    RST1 = 1'b0;
    b1.WR_EN = 1'b1; b1.Din = 8'h3C;
    @(posedge CLK); #1;
    b1.WR_EN = 1'b0;
    chk("f_post_rst", b1.DOut, 8'h3C);
    chk("f_post_cnt", b1.Count, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
